// File: rtl/vga_vram_arbiter.sv
// Arbitrates N VRAM client channels onto one SDRAM request port. Round-robin grant
// with a per-channel burst limit; an in-order tag FIFO routes read returns back to their issuer.
module vga_vram_arbiter #(
    parameter int P_NCH   = 2,
    parameter int P_AW    = 20,
    parameter int P_DW    = 16,
    parameter int P_BURST = 4,
    parameter int P_RDQ   = 8
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iRESET_SYNC,
    input  logic [P_NCH-1:0]          iREQ_VALID,
    input  logic [P_NCH-1:0]          iREQ_RW,
    input  logic [P_NCH*P_AW-1:0]     iREQ_ADDR,
    input  logic [P_NCH*P_DW-1:0]     iREQ_DATA,
    input  logic [P_NCH*P_DW/8-1:0]   iREQ_BYTEENA,
    output logic [P_NCH-1:0]          oREQ_BUSY,
    output logic [P_NCH-1:0]          oRD_VALID,
    output logic [P_DW-1:0]           oRD_DATA,
    output logic                      oRD_ERR,
    output logic                      oMEM_VALID,
    output logic                      oMEM_RW,
    output logic [31:0]               oMEM_ADDR,
    output logic [P_DW-1:0]           oMEM_DATA,
    output logic [P_DW/8-1:0]         oMEM_BYTEENA,
    input  logic                      iMEM_BUSY,
    input  logic                      iMEM_VALID,
    input  logic [P_DW-1:0]           iMEM_DATA
);

    localparam int             CW        = $clog2(P_NCH);
    localparam int             QW        = $clog2(P_RDQ);
    localparam int             BW        = P_DW / 8;
    localparam logic [3:0]     BURST_LIM = 4'(P_BURST);
    localparam logic [QW:0]    Q_FULL    = (QW+1)'(P_RDQ);
    localparam logic [QW:0]    Q_ONE     = (QW+1)'(1);
    localparam logic [QW-1:0]  P_ONE     = QW'(1);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // output stage and arbitration state
    logic              vld_p1;
    logic              rw_p1;
    logic [P_AW-1:0]   addr_p1;
    logic [P_DW-1:0]   data_p1;
    logic [BW-1:0]     be_p1;
    logic [CW-1:0]     last_p1;
    logic [3:0]        burst_cnt;

    // read tag FIFO
    logic [CW-1:0]     q_mem [P_RDQ];
    logic [QW-1:0]     q_wr;
    logic [QW-1:0]     q_rd;
    logic [QW:0]       q_cnt;
    logic              rd_err;

    logic              rst_any;
    logic              q_full;
    logic              q_empty;
    logic [P_NCH-1:0]  elig;
    logic [P_NCH-1:0]  grant;
    logic [CW-1:0]     sel;
    logic              found;
    int                last_i;
    logic              accept;
    logic              push;
    logic              pop;
    logic              g_rw;
    logic [P_AW-1:0]   g_addr;
    logic [P_DW-1:0]   g_data;
    logic [BW-1:0]     g_be;

    assign rst_any = !inRESET || iRESET_SYNC;
    assign q_full  = (q_cnt == Q_FULL);
    assign q_empty = (q_cnt == '0);
    assign elig    = iREQ_VALID & (iREQ_RW | {P_NCH{!q_full}});

    // The last-granted channel keeps the port until its burst allowance runs out,
    // then the scan starts just after it and visits it last.
    always_comb begin
        grant  = '0;
        sel    = '0;
        found  = 1'b0;
        last_i = int'(last_p1);
        if (!iMEM_BUSY && !rst_any) begin
            for (int i = 0; i < P_NCH; i++) begin
                if (i == last_i && elig[i] && burst_cnt < BURST_LIM) begin
                    grant[i] = 1'b1;
                    sel      = CW'(i);
                    found    = 1'b1;
                end
            end
            for (int k = 1; k <= P_NCH; k++) begin
                for (int i = 0; i < P_NCH; i++) begin
                    if (!found && elig[i] && i == (last_i + k) % P_NCH) begin
                        grant[i] = 1'b1;
                        sel      = CW'(i);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        g_rw   = 1'b0;
        g_addr = '0;
        g_data = '0;
        g_be   = '0;
        for (int i = 0; i < P_NCH; i++) begin
            if (grant[i]) begin
                g_rw   = iREQ_RW[i];
                g_addr = iREQ_ADDR[i*P_AW +: P_AW];
                g_data = iREQ_DATA[i*P_DW +: P_DW];
                g_be   = iREQ_BYTEENA[i*BW +: BW];
            end
        end
    end

    assign accept    = |grant;
    assign push      = accept && !g_rw;
    assign pop       = iMEM_VALID && !q_empty;
    assign oREQ_BUSY = ~grant;

    // stage p1: registered memory request; held while memory is busy
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            vld_p1    <= 1'b0;
            rw_p1     <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            be_p1     <= '0;
            last_p1   <= '0;
            burst_cnt <= '0;
        end else if (iRESET_SYNC) begin
            vld_p1    <= 1'b0;
            rw_p1     <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            be_p1     <= '0;
            last_p1   <= '0;
            burst_cnt <= '0;
        end else if (!iMEM_BUSY) begin
            if (accept) begin
                vld_p1    <= 1'b1;
                rw_p1     <= g_rw;
                addr_p1   <= g_addr;
                data_p1   <= g_data;
                be_p1     <= g_be;
                last_p1   <= sel;
                burst_cnt <= (sel == last_p1) ? sat_inc(burst_cnt) : 4'd1;
            end else begin
                vld_p1    <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

    assign oMEM_VALID   = vld_p1;
    assign oMEM_RW      = rw_p1;
    assign oMEM_ADDR    = 32'(addr_p1);
    assign oMEM_DATA    = data_p1;
    assign oMEM_BYTEENA = be_p1;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            q_wr   <= '0;
            q_rd   <= '0;
            q_cnt  <= '0;
            rd_err <= 1'b0;
        end else if (iRESET_SYNC) begin
            q_wr   <= '0;
            q_rd   <= '0;
            q_cnt  <= '0;
            rd_err <= 1'b0;
        end else begin
            if (push)
                q_wr <= q_wr + P_ONE;
            if (pop)
                q_rd <= q_rd + P_ONE;
            if (push && !pop)
                q_cnt <= q_cnt + Q_ONE;
            else if (!push && pop)
                q_cnt <= q_cnt - Q_ONE;
            if (iMEM_VALID && q_empty)
                rd_err <= 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < P_RDQ; i++)
                q_mem[i] <= '0;
        end else if (iRESET_SYNC) begin
            for (int i = 0; i < P_RDQ; i++)
                q_mem[i] <= '0;
        end else if (push) begin
            q_mem[q_wr] <= sel;
        end
    end

    // Read returns are steered combinationally to the channel at the FIFO head.
    always_comb begin
        oRD_VALID = '0;
        for (int i = 0; i < P_NCH; i++) begin
            if (pop && q_mem[q_rd] == CW'(i))
                oRD_VALID[i] = 1'b1;
        end
    end

    assign oRD_DATA = iMEM_DATA;
    assign oRD_ERR  = rd_err;

endmodule
